// File: rtl/flop_r_pkg.sv
// rtl/flop_r_pkg.sv - shared width and word type for the flop_r register
//
// Purpose: default datapath width and the matching word type for users of
//          flop_r that take the default width.
// Contents:
//   FLOP_R_DEFAULT_W  default register width in bits (64)
//   flop_r_word_t     logic vector of FLOP_R_DEFAULT_W bits
package flop_r_pkg;

  localparam int FLOP_R_DEFAULT_W = 64;

  typedef logic [FLOP_R_DEFAULT_W-1:0] flop_r_word_t;

endpackage : flop_r_pkg

// File: rtl/flop_r_bit.sv
// rtl/flop_r_bit.sv - 1-bit register cell with synchronous reset and load enable
//
// Purpose: storage for one bit of flop_r.
// Ports:
//   clk      in   1  clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   rst_val  in   1  value loaded into q on reset
//   en       in   1  load enable (tie high for load-every-cycle)
//   d        in   1  data input
//   q        out  1  registered output
module flop_r_bit (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over the enable, so a held register still clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : flop_r_bit

// File: rtl/flop_r.sv
// rtl/flop_r.sv - N-bit D register with synchronous active-high reset
//
// Purpose: generic pipeline/state register; q follows d one clock later,
//          with no combinational path from d to q.
// Parameters:
//   N          data width in bits (>=1), default FLOP_R_DEFAULT_W
//   RESET_VAL  value loaded into q on reset, default all zeros
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  synchronous, active-high reset
//   en     in   1  load enable; present only when FLOP_R_LOAD_EN is defined
//   d      in   N  data input
//   q      out  N  registered output
// Configuration macro: FLOP_R_LOAD_EN (adds the en port; when undefined the
//   register loads d on every edge).
module flop_r
  import flop_r_pkg::*;
#(
  parameter int           N         = FLOP_R_DEFAULT_W,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
`ifdef FLOP_R_LOAD_EN
  input  logic         en,
`endif
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic load;

`ifdef FLOP_R_LOAD_EN
  assign load = en;
`else
  assign load = 1'b1;
`endif

  // One cell per bit; each cell takes its own bit of the reset value.
  for (genvar i = 0; i < N; i++) begin : g_bit
    flop_r_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VAL[i]),
      .en      (load),
      .d       (d[i]),
      .q       (q[i])
    );
  end

endmodule : flop_r

// File: tb/tb_flop_r.sv
// tb/tb_flop_r.sv - directed self-checking bench for flop_r
module tb_flop_r;
  import flop_r_pkg::*;

  logic               clk;
  logic               reset;
  logic [31:0]        d32;
  logic [31:0]        q32;
  flop_r_word_t       d64;
  flop_r_word_t       q64;
  logic [0:0]         d1;
  logic [0:0]         q1;
`ifdef FLOP_R_LOAD_EN
  logic               en;
`endif

  int errors;
  int checks;

  flop_r #(.N(32)) u_dut32 (
    .clk   (clk),
    .reset (reset),
`ifdef FLOP_R_LOAD_EN
    .en    (en),
`endif
    .d     (d32),
    .q     (q32)
  );

  flop_r #(.N(64)) u_dut64 (
    .clk   (clk),
    .reset (reset),
`ifdef FLOP_R_LOAD_EN
    .en    (en),
`endif
    .d     (d64),
    .q     (q64)
  );

  flop_r #(.N(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
`ifdef FLOP_R_LOAD_EN
    .en    (en),
`endif
    .d     (d1),
    .q     (q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Change inputs on the falling edge, then sample 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    d32   = 32'h0;
    d64   = '0;
    d1    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (q32 !== 32'h0) begin
        errors++;
        $display("FAIL reset_edge%0d q32: got %h want %h", i, q32, 32'h0);
      end
    end
    checks++;
    if (q64 !== 64'h0) begin
      errors++;
      $display("FAIL reset q64: got %h want %h", q64, 64'h0);
    end
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL reset q1: got %b want 0", q1);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 1'b0;
      d32   = 32'(i);
      step();
      checks++;
      if (q32 !== 32'(i)) begin
        errors++;
        $display("FAIL stream%0d: got %h want %h", i, q32, 32'(i));
      end
    end
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    reset = 1'b1;
    d32   = 32'hDEADBEEF;
    step();
    checks++;
    if (q32 !== 32'h0) begin
      errors++;
      $display("FAIL override_reset: got %h want %h", q32, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if (q32 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL override_release: got %h want %h", q32, 32'hDEADBEEF);
    end
  endtask

  task automatic test_mid_stream_reset();
    @(negedge clk);
    reset = 1'b0;
    d32   = 32'd5;
    step();
    checks++;
    if (q32 !== 32'd5) begin
      errors++;
      $display("FAIL mid_d5: got %h want %h", q32, 32'd5);
    end
    @(negedge clk);
    reset = 1'b1;
    d32   = 32'd6;
    step();
    checks++;
    if (q32 !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", q32, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    d32   = 32'd7;
    step();
    checks++;
    if (q32 !== 32'd7) begin
      errors++;
      $display("FAIL mid_d7: got %h want %h", q32, 32'd7);
    end
  endtask

  // A reset pulse that starts and ends between edges must not touch q.
  task automatic test_reset_between_edges();
    @(negedge clk);
    reset = 1'b0;
    d32   = 32'h11;
    step();
    checks++;
    if (q32 !== 32'h11) begin
      errors++;
      $display("FAIL glitch_load: got %h want %h", q32, 32'h11);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (q32 !== 32'h11) begin
      errors++;
      $display("FAIL glitch_async: got %h want %h", q32, 32'h11);
    end
    reset = 1'b0;
    @(negedge clk);
    d32 = 32'h22;
    step();
    checks++;
    if (q32 !== 32'h22) begin
      errors++;
      $display("FAIL glitch_after: got %h want %h", q32, 32'h22);
    end
  endtask

  task automatic test_width();
    @(negedge clk);
    reset = 1'b0;
    d64   = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    checks++;
    if (q64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL width64_ones: got %h want %h", q64, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    @(negedge clk);
    d64 = 64'h8000_0000_0000_0001;
    step();
    checks++;
    if (q64 !== 64'h8000_0000_0000_0001) begin
      errors++;
      $display("FAIL width64_ends: got %h want %h", q64, 64'h8000_0000_0000_0001);
    end
    for (int i = 0; i < 4; i++) begin
      logic [0:0] exp1;
      exp1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      d1 = exp1;
      checks++;
      if (i > 0 && q1 !== ~exp1) begin
        errors++;
        $display("FAIL width1_hold%0d: got %b want %b", i, q1, ~exp1);
      end
      step();
      checks++;
      if (q1 !== exp1) begin
        errors++;
        $display("FAIL width1_toggle%0d: got %b want %b", i, q1, exp1);
      end
    end
  endtask

`ifdef FLOP_R_LOAD_EN
  task automatic test_load_en();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    d32   = 32'd3;
    step();
    checks++;
    if (q32 !== 32'd3) begin
      errors++;
      $display("FAIL en_load3: got %h want %h", q32, 32'd3);
    end
    @(negedge clk);
    en  = 1'b0;
    d32 = 32'd9;
    step();
    checks++;
    if (q32 !== 32'd3) begin
      errors++;
      $display("FAIL en_hold: got %h want %h", q32, 32'd3);
    end
    @(negedge clk);
    en = 1'b1;
    step();
    checks++;
    if (q32 !== 32'd9) begin
      errors++;
      $display("FAIL en_load9: got %h want %h", q32, 32'd9);
    end
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (q32 !== 32'd0) begin
      errors++;
      $display("FAIL en_reset_wins: got %h want %h", q32, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    d32    = '0;
    d64    = '0;
    d1     = '0;
`ifdef FLOP_R_LOAD_EN
    en     = 1'b1;
`endif
    test_reset();
    test_stream();
    test_reset_override();
    test_mid_stream_reset();
    test_reset_between_edges();
    test_width();
`ifdef FLOP_R_LOAD_EN
    test_load_en();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_flop_r
